// File: rtl/bi_codec_seg_if.sv
// Handshake, payload and statistics bundle of the segmented bus-invert codec.
// The codec side uses the slave modport; the datapath/bench side uses master.
interface bi_codec_seg_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SEGMENTS = 1,
  parameter int unsigned CNT_W    = 16
);
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic [SEGMENTS-1:0] in_inv;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic [SEGMENTS-1:0] out_inv;
  logic                stat_clear;
  logic [CNT_W-1:0]    trans_raw;
  logic [CNT_W-1:0]    trans_coded;

  modport master (
    output mode, in_valid, in_data, in_inv, out_ready, stat_clear,
    input  in_ready, out_valid, out_data, out_inv, trans_raw, trans_coded
  );

  modport slave (
    input  mode, in_valid, in_data, in_inv, out_ready, stat_clear,
    output in_ready, out_valid, out_data, out_inv, trans_raw, trans_coded
  );
endinterface

// File: rtl/bi_codec_seg.sv
// Segmented bus-invert encoder/decoder with internal bus history, one-deep
// output register and saturating raw/coded transition statistics.
module bi_codec_seg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SEGMENTS = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  bi_codec_seg_if.slave  bus
);

  localparam int unsigned SW   = WIDTH / SEGMENTS;
  localparam int unsigned IW   = $clog2(WIDTH + SEGMENTS + 1);
  localparam int unsigned HW   = $clog2(SW + 2) + 1;
  localparam int unsigned SUMW = ((CNT_W > IW) ? CNT_W : IW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if ((WIDTH % SEGMENTS) != 0) begin : g_bad_split
    $error("bi_codec_seg: WIDTH must be a multiple of SEGMENTS");
  end

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEGMENTS-1:0] r_out_inv;
  logic [WIDTH-1:0]    r_bus_q;
  logic [SEGMENTS-1:0] r_inv_q;
  logic [WIDTH-1:0]    r_raw_q;
  logic [CNT_W-1:0]    r_trans_raw;
  logic [CNT_W-1:0]    r_trans_coded;

  logic                w_accept;
  logic [WIDTH-1:0]    w_diff;
  logic [HW-1:0]       w_hd;
  logic [HW-1:0]       w_cost_keep;
  logic [HW-1:0]       w_cost_inv;
  logic [WIDTH-1:0]    w_enc_data;
  logic [SEGMENTS-1:0] w_enc_inv;
  logic [WIDTH-1:0]    w_dec_data;
  logic [WIDTH-1:0]    w_raw;
  logic [WIDTH-1:0]    w_coded;
  logic [SEGMENTS-1:0] w_inv;
  logic [IW-1:0]       w_inc_raw;
  logic [IW-1:0]       w_inc_coded;
  logic [SUMW-1:0]     w_sum_raw;
  logic [SUMW-1:0]     w_sum_coded;
  logic [CNT_W-1:0]    w_nxt_raw;
  logic [CNT_W-1:0]    w_nxt_coded;

  function automatic logic [IW-1:0] f_popcnt(input logic [WIDTH+SEGMENTS-1:0] v);
    logic [IW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(WIDTH + SEGMENTS); i++) begin
      cnt = cnt + IW'(v[i]);
    end
    return cnt;
  endfunction

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_diff   = bus.in_data ^ r_bus_q;

  // Per-segment invert decision; the invert line's own toggle is part of each cost.
  always_comb begin
    w_hd        = '0;
    w_cost_keep = '0;
    w_cost_inv  = '0;
    w_enc_data  = '0;
    w_enc_inv   = '0;
    w_dec_data  = '0;
    for (int k = 0; k < int'(SEGMENTS); k++) begin
      w_hd = '0;
      for (int j = 0; j < int'(SW); j++) begin
        w_hd = w_hd + HW'(w_diff[k*SW + j]);
      end
      w_cost_keep  = w_hd + HW'(r_inv_q[k]);
      w_cost_inv   = HW'(SW) - w_hd + HW'(!r_inv_q[k]);
      w_enc_inv[k] = (w_cost_inv < w_cost_keep);
      w_enc_data[k*SW +: SW] = bus.in_data[k*SW +: SW] ^ {SW{w_enc_inv[k]}};
      w_dec_data[k*SW +: SW] = bus.in_data[k*SW +: SW] ^ {SW{bus.in_inv[k]}};
    end
  end

  assign w_raw   = bus.mode ? w_dec_data  : bus.in_data;
  assign w_coded = bus.mode ? bus.in_data : w_enc_data;
  assign w_inv   = bus.mode ? bus.in_inv  : w_enc_inv;

  assign w_inc_raw   = f_popcnt({w_raw ^ r_raw_q, {SEGMENTS{1'b0}}});
  assign w_inc_coded = f_popcnt({w_coded ^ r_bus_q, w_inv ^ r_inv_q});

  // Saturation is judged on the widened sum so the counter never wraps.
  assign w_sum_raw   = SUMW'(r_trans_raw)   + SUMW'(w_inc_raw);
  assign w_sum_coded = SUMW'(r_trans_coded) + SUMW'(w_inc_coded);
  assign w_nxt_raw   = (w_sum_raw   > SUMW'(CNT_MAX)) ? CNT_MAX : w_sum_raw[CNT_W-1:0];
  assign w_nxt_coded = (w_sum_coded > SUMW'(CNT_MAX)) ? CNT_MAX : w_sum_coded[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_inv     <= '0;
      r_bus_q       <= '0;
      r_inv_q       <= '0;
      r_raw_q       <= '0;
      r_trans_raw   <= '0;
      r_trans_coded <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.mode ? w_dec_data : w_enc_data;
        r_out_inv   <= w_inv;
        r_bus_q     <= w_coded;
        r_inv_q     <= w_inv;
        r_raw_q     <= w_raw;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Clear beats a coincident increment; history above still advances.
      if (bus.stat_clear) begin
        r_trans_raw   <= '0;
        r_trans_coded <= '0;
      end else if (w_accept) begin
        r_trans_raw   <= w_nxt_raw;
        r_trans_coded <= w_nxt_coded;
      end
    end
  end

  assign bus.in_ready    = !r_out_valid || bus.out_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_inv     = r_out_inv;
  assign bus.trans_raw   = r_trans_raw;
  assign bus.trans_coded = r_trans_coded;

endmodule

// File: tb/tb_bi_codec_seg.sv
// Directed bench: one 8-bit single-segment codec with 4-bit counters and one
// 8-bit two-segment codec, each checked against hand-computed vectors.
module tb_bi_codec_seg;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bi_codec_seg_if #(.WIDTH(8), .SEGMENTS(1), .CNT_W(4))  ifa ();
  bi_codec_seg_if #(.WIDTH(8), .SEGMENTS(2), .CNT_W(16)) ifb ();

  bi_codec_seg #(.WIDTH(8), .SEGMENTS(1), .CNT_W(4))  u_a (.clk(clk), .rst(rst), .bus(ifa));
  bi_codec_seg #(.WIDTH(8), .SEGMENTS(2), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_xfer(input logic m, input logic [7:0] d, input logic inv);
    ifa.mode     = m;
    ifa.in_data  = d;
    ifa.in_inv   = inv;
    ifa.in_valid = 1'b1;
    step();
    ifa.in_valid = 1'b0;
  endtask

  task automatic b_xfer(input logic m, input logic [7:0] d, input logic [1:0] inv);
    ifb.mode     = m;
    ifb.in_data  = d;
    ifb.in_inv   = inv;
    ifb.in_valid = 1'b1;
    step();
    ifb.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ifa.mode = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_inv = '0;
    ifa.out_ready = 1'b1; ifa.stat_clear = 1'b0;
    ifb.mode = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_inv = '0;
    ifb.out_ready = 1'b1; ifb.stat_clear = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(ifa.out_data), 32'h00);
    check_eq("rst_out_inv", 32'(ifa.out_inv), 32'd0);
    check_eq("rst_trans_raw", 32'(ifa.trans_raw), 32'd0);
    check_eq("rst_trans_coded", 32'(ifa.trans_coded), 32'd0);
    check_eq("rst_in_ready", 32'(ifa.in_ready), 32'd1);

    // Encode 0x0F from zero history: keep
    a_xfer(1'b0, 8'h0F, 1'b0);
    check_eq("enc0f_valid", 32'(ifa.out_valid), 32'd1);
    check_eq("enc0f_data", 32'(ifa.out_data), 32'h0F);
    check_eq("enc0f_inv", 32'(ifa.out_inv), 32'd0);
    check_eq("enc0f_raw", 32'(ifa.trans_raw), 32'd4);
    check_eq("enc0f_coded", 32'(ifa.trans_coded), 32'd4);

    // Encode 0xF0: HD=8 -> invert
    a_xfer(1'b0, 8'hF0, 1'b0);
    check_eq("encf0_data", 32'(ifa.out_data), 32'h0F);
    check_eq("encf0_inv", 32'(ifa.out_inv), 32'd1);
    check_eq("encf0_raw", 32'(ifa.trans_raw), 32'd12);
    check_eq("encf0_coded", 32'(ifa.trans_coded), 32'd5);

    // Decode 0x0F with invert line set
    a_xfer(1'b1, 8'h0F, 1'b1);
    check_eq("dec_inv1_data", 32'(ifa.out_data), 32'hF0);
    check_eq("dec_inv1_inv", 32'(ifa.out_inv), 32'd1);
    check_eq("dec_inv1_raw", 32'(ifa.trans_raw), 32'd12);
    check_eq("dec_inv1_coded", 32'(ifa.trans_coded), 32'd5);

    // Decode 0x0F plain: raw +8 saturates at 15, coded +1
    a_xfer(1'b1, 8'h0F, 1'b0);
    check_eq("dec_inv0_data", 32'(ifa.out_data), 32'h0F);
    check_eq("dec_inv0_inv", 32'(ifa.out_inv), 32'd0);
    check_eq("sat_raw", 32'(ifa.trans_raw), 32'd15);
    check_eq("dec_inv0_coded", 32'(ifa.trans_coded), 32'd6);

    // Drain, then load a word with downstream stalled
    step();
    check_eq("drain_valid", 32'(ifa.out_valid), 32'd0);
    ifa.out_ready = 1'b0;
    a_xfer(1'b0, 8'h00, 1'b0);
    check_eq("stall_load_data", 32'(ifa.out_data), 32'h00);
    check_eq("sat_hold_raw", 32'(ifa.trans_raw), 32'd15);
    check_eq("stall_load_coded", 32'(ifa.trans_coded), 32'd10);

    // Backpressure: 3 stalled cycles with a pending word
    ifa.mode = 1'b0; ifa.in_data = 8'hF0; ifa.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_in_ready", 32'(ifa.in_ready), 32'd0);
      step();
      check_eq("stall_valid", 32'(ifa.out_valid), 32'd1);
      check_eq("stall_data", 32'(ifa.out_data), 32'h00);
      check_eq("stall_inv", 32'(ifa.out_inv), 32'd0);
      check_eq("stall_coded", 32'(ifa.trans_coded), 32'd10);
    end
    ifa.out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", 32'(ifa.in_ready), 32'd1);
    step();
    ifa.in_valid = 1'b0;
    check_eq("release_data", 32'(ifa.out_data), 32'hF0);
    check_eq("release_inv", 32'(ifa.out_inv), 32'd0);
    check_eq("release_coded", 32'(ifa.trans_coded), 32'd14);

    // stat_clear coinciding with an accept: clear wins, history advances
    ifa.stat_clear = 1'b1;
    a_xfer(1'b0, 8'h0F, 1'b0);
    ifa.stat_clear = 1'b0;
    check_eq("clr_data", 32'(ifa.out_data), 32'hF0);
    check_eq("clr_inv", 32'(ifa.out_inv), 32'd1);
    check_eq("clr_raw", 32'(ifa.trans_raw), 32'd0);
    check_eq("clr_coded", 32'(ifa.trans_coded), 32'd0);
    a_xfer(1'b0, 8'hF0, 1'b0);
    check_eq("post_clr_data", 32'(ifa.out_data), 32'hF0);
    check_eq("post_clr_inv", 32'(ifa.out_inv), 32'd0);
    check_eq("post_clr_raw", 32'(ifa.trans_raw), 32'd8);
    check_eq("post_clr_coded", 32'(ifa.trans_coded), 32'd1);

    // Reset mid-stream discards the held word and history
    ifa.in_data = 8'h33; ifa.in_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifa.in_valid = 1'b0;
    check_eq("midrst_valid", 32'(ifa.out_valid), 32'd0);
    check_eq("midrst_raw", 32'(ifa.trans_raw), 32'd0);
    a_xfer(1'b0, 8'h0F, 1'b0);
    check_eq("midrst_enc_data", 32'(ifa.out_data), 32'h0F);
    check_eq("midrst_enc_inv", 32'(ifa.out_inv), 32'd0);
    check_eq("midrst_enc_raw", 32'(ifa.trans_raw), 32'd4);
    check_eq("midrst_enc_coded", 32'(ifa.trans_coded), 32'd4);

    // Two segments: upper nibble inverts, lower kept
    do_reset();
    b_xfer(1'b0, 8'hE1, 2'b00);
    check_eq("seg_e1_data", 32'(ifb.out_data), 32'h11);
    check_eq("seg_e1_inv", 32'(ifb.out_inv), 32'h2);
    check_eq("seg_e1_raw", 32'(ifb.trans_raw), 32'd4);
    check_eq("seg_e1_coded", 32'(ifb.trans_coded), 32'd3);

    // Decode with only the lower segment inverted
    b_xfer(1'b1, 8'h5A, 2'b01);
    check_eq("seg_dec_data", 32'(ifb.out_data), 32'h55);
    check_eq("seg_dec_inv", 32'(ifb.out_inv), 32'h1);

    // Balanced upper nibble from reset stays uninverted
    do_reset();
    b_xfer(1'b0, 8'hC0, 2'b00);
    check_eq("seg_c0_data", 32'(ifb.out_data), 32'hC0);
    check_eq("seg_c0_inv", 32'(ifb.out_inv), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
